// File: rtl/l1i_set_assoc_cache.sv
// l1i_set_assoc_cache: set-associative L1 instruction cache with a two-stage
// lookup pipeline (request register, then tag compare) and a single
// outstanding miss handled by an IDLE / MISS_WAIT / REPLAY controller.
// Build option: define L1I_TREE_PLRU_EN to use tree-PLRU replacement;
// otherwise each set uses a round-robin fill counter.
module l1i_set_assoc_cache #(
    parameter int addrWidth   = 64,
    parameter int lineWidth   = 512,
    parameter int offsetWidth = 6,
    parameter int indexWidth  = 6,
    parameter int numWays     = 4,
    parameter int bundleInsts = 4,
    parameter int PidSize     = 20,
    parameter int TidSize     = 16
) (
    input  logic                               clock_i,
    input  logic                               cacheResetN_i,
    input  logic                               fetchEnable_i,
    input  logic                               fetchStall_i,
    input  logic [addrWidth-1:0]               fetchAddress_i,
    input  logic [PidSize-1:0]                 fetchPid_i,
    input  logic [TidSize-1:0]                 fetchTid_i,
    input  logic                               fillValid_i,
    input  logic [addrWidth-1:0]               fillAddress_i,
    input  logic [lineWidth-1:0]               fillLine_i,
    input  logic                               flush_i,
    output logic                               outputEnable_o,
    output logic [bundleInsts*32-1:0]          outputBundle_o,
    output logic [addrWidth-1:0]               bundleAddress_o,
    output logic [$clog2(bundleInsts):0]       bundleLen_o,
    output logic [PidSize-1:0]                 bundlePid_o,
    output logic [TidSize-1:0]                 bundleTid_o,
    output logic                               cacheMiss_o,
    output logic [addrWidth-1:0]               missedAddress_o,
    output logic [PidSize-1:0]                 missedPid_o,
    output logic [TidSize-1:0]                 missedTid_o,
    output logic                               busy_o
);

    localparam int TagW        = addrWidth - indexWidth - offsetWidth;
    localparam int NumSets     = 1 << indexWidth;
    localparam int WayW        = $clog2(numWays);
    localparam int InstPerLine = lineWidth / 32;
    localparam int InstIdxW    = offsetWidth - 2;
    localparam int BundleW     = bundleInsts * 32;
    localparam int LenW        = $clog2(bundleInsts) + 1;
`ifdef L1I_TREE_PLRU_EN
    localparam int ReplW       = numWays - 1;
`else
    localparam int ReplW       = WayW;
`endif

    typedef enum logic [1:0] {IDLE, MISS_WAIT, REPLAY} state_t;

    // Lowest-numbered invalid way; only meaningful when some way is invalid.
    function automatic logic [WayW-1:0] firstInvalid(input logic [numWays-1:0] v);
        logic [WayW-1:0] result;
        result = '0;
        for (int w = numWays - 1; w >= 0; w--) begin
            if (!v[w]) result = WayW'(w);
        end
        return result;
    endfunction

`ifdef L1I_TREE_PLRU_EN
    // Heap-ordered tree: node n has children 2n and 2n+1; a set bit points right.
    function automatic logic [WayW-1:0] plruVictim(input logic [ReplW-1:0] t);
        int node;
        node = 1;
        for (int l = 0; l < WayW; l++) begin
            node = 2 * node + int'(t[node-1]);
        end
        return WayW'(node - numWays);
    endfunction

    // Point every node on the path away from the way just used.
    function automatic logic [ReplW-1:0] plruTouch(input logic [ReplW-1:0] t,
                                                   input logic [WayW-1:0]  way);
        logic [ReplW-1:0] r;
        int node;
        r    = t;
        node = 1;
        for (int l = 0; l < WayW; l++) begin
            r[node-1] = ~way[WayW-1-l];
            node      = 2 * node + int'(way[WayW-1-l]);
        end
        return r;
    endfunction
`endif

    // Cache arrays: valid bits and replacement state are reset, tags/data are not.
    logic [NumSets-1:0][numWays-1:0] valid_q;
    logic [ReplW-1:0]                repl_q [NumSets];
    logic [TagW-1:0]                 tag_q  [NumSets][numWays];
    logic [lineWidth-1:0]            data_q [NumSets][numWays];

    // Pipeline and miss bookkeeping.
    state_t                 state_q, state_d;
    logic                   vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic [addrWidth-1:0]   addr_p1_q, addr_p2_q, missAddr_q;
    logic [PidSize-1:0]     pid_p1_q, pid_p2_q, missPid_q;
    logic [TidSize-1:0]     tid_p1_q, tid_p2_q, missTid_q;

    // Registered outputs.
    logic                   outEn_q, outEn_d, cacheMiss_q, missPulse_d;
    logic [BundleW-1:0]     bundle_q;
    logic [addrWidth-1:0]   bundleAddr_q, missedAddr_q;
    logic [LenW-1:0]        bundleLen_q;
    logic [PidSize-1:0]     bundlePid_q, missedPid_q;
    logic [TidSize-1:0]     bundleTid_q, missedTid_q;

    // Controller strobes.
    logic loadP1, loadP2Fetch, loadP2Miss, outLoad, missLoad, hitUpd;

    // Fill side.
    logic                   fillWe, fillLineMatch, fillHitAny;
    logic [TagW-1:0]        fillTag;
    logic [indexWidth-1:0]  fillIdx;
    logic [WayW-1:0]        fillWay, fillHitWay;
    logic [ReplW-1:0]       replFill, replHit;

    // Stage-2 lookup.
    logic [TagW-1:0]        tag2;
    logic [indexWidth-1:0]  idx2;
    logic [InstIdxW-1:0]    inst2;
    logic                   lookupHit;
    logic [WayW-1:0]        hitWay;
    logic [lineWidth-1:0]   hitLine, lineShift;
    logic [BundleW-1:0]     bundle2;
    logic [LenW-1:0]        len2;
    int                     availInsts, validInsts;

    assign fillTag       = fillAddress_i[addrWidth-1 -: TagW];
    assign fillIdx       = fillAddress_i[offsetWidth +: indexWidth];
    assign fillWe        = fillValid_i && !flush_i;
    assign fillLineMatch = fillAddress_i[addrWidth-1:offsetWidth] == missAddr_q[addrWidth-1:offsetWidth];

    assign tag2  = addr_p2_q[addrWidth-1 -: TagW];
    assign idx2  = addr_p2_q[offsetWidth +: indexWidth];
    assign inst2 = addr_p2_q[offsetWidth-1:2];

    logic unusedFillOffset;
    assign unusedFillOffset = ^fillAddress_i[offsetWidth-1:0];

    // Fill victim: reuse a way already holding the line, else first invalid, else policy.
    always_comb begin
        fillHitAny = 1'b0;
        fillHitWay = '0;
        fillWay    = '0;
        for (int w = 0; w < numWays; w++) begin
            if (valid_q[fillIdx][w] && tag_q[fillIdx][w] == fillTag) begin
                fillHitAny = 1'b1;
                fillHitWay = WayW'(w);
            end
        end
        if (fillHitAny) begin
            fillWay = fillHitWay;
        end else if (!(&valid_q[fillIdx])) begin
            fillWay = firstInvalid(valid_q[fillIdx]);
        end else begin
`ifdef L1I_TREE_PLRU_EN
            fillWay = plruVictim(repl_q[fillIdx]);
`else
            fillWay = repl_q[fillIdx];
`endif
        end
    end

    // Tag compare against the arrays as they look after this cycle's fill.
    always_comb begin
        lookupHit = 1'b0;
        hitWay    = '0;
        hitLine   = '0;
        for (int w = 0; w < numWays; w++) begin
            if (fillWe && fillIdx == idx2 && fillWay == WayW'(w)) begin
                if (fillTag == tag2) begin
                    lookupHit = 1'b1;
                    hitWay    = WayW'(w);
                    hitLine   = fillLine_i;
                end
            end else if (valid_q[idx2][w] && tag_q[idx2][w] == tag2) begin
                lookupHit = 1'b1;
                hitWay    = WayW'(w);
                hitLine   = data_q[idx2][w];
            end
        end
    end

    // Left-justified bundle starting at the requested instruction, tail slots zeroed.
    always_comb begin
        availInsts = InstPerLine - int'(inst2);
        validInsts = (availInsts < bundleInsts) ? availInsts : bundleInsts;
        lineShift  = hitLine >> (32 * int'(inst2));
        bundle2    = '0;
        for (int k = 0; k < bundleInsts; k++) begin
            if (k < validInsts) bundle2[32*k +: 32] = lineShift[32*k +: 32];
        end
        len2 = LenW'(validInsts);
    end

    // Replacement next-state for fill and for hit (hit applied on top of a same-set fill).
`ifdef L1I_TREE_PLRU_EN
    always_comb begin
        replFill = plruTouch(repl_q[fillIdx], fillWay);
        replHit  = plruTouch((fillWe && fillIdx == idx2) ? replFill : repl_q[idx2], hitWay);
    end
`else
    always_comb begin
        replFill = repl_q[fillIdx] + 1'b1;
        replHit  = repl_q[idx2];
    end
    logic unusedHitSide;
    assign unusedHitSide = ^{hitWay, replHit, hitUpd};
`endif

    // Controller next-state and pipeline strobes.
    always_comb begin
        state_d     = state_q;
        vld_p1_d    = vld_p1_q;
        vld_p2_d    = vld_p2_q;
        outEn_d     = outEn_q;
        missPulse_d = 1'b0;
        loadP1      = 1'b0;
        loadP2Fetch = 1'b0;
        loadP2Miss  = 1'b0;
        outLoad     = 1'b0;
        missLoad    = 1'b0;
        hitUpd      = 1'b0;
        if (flush_i) begin
            state_d  = IDLE;
            vld_p1_d = 1'b0;
            vld_p2_d = 1'b0;
            outEn_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fetchStall_i) begin
                        outEn_d = 1'b0;
                        if (vld_p2_q && !lookupHit) begin
                            state_d     = MISS_WAIT;
                            missPulse_d = 1'b1;
                            missLoad    = 1'b1;
                            vld_p1_d    = 1'b0;
                            vld_p2_d    = 1'b0;
                        end else begin
                            if (vld_p2_q) begin
                                outLoad = 1'b1;
                                outEn_d = 1'b1;
                                hitUpd  = 1'b1;
                            end
                            vld_p2_d    = vld_p1_q;
                            loadP2Fetch = vld_p1_q;
                            vld_p1_d    = fetchEnable_i;
                            loadP1      = fetchEnable_i;
                        end
                    end
                end
                MISS_WAIT: begin
                    outEn_d = 1'b0;
                    if (fillWe && fillLineMatch) state_d = REPLAY;
                end
                REPLAY: begin
                    outEn_d = 1'b0;
                    if (!fetchStall_i) begin
                        vld_p2_d   = 1'b1;
                        loadP2Miss = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clock_i or negedge cacheResetN_i) begin
        if (!cacheResetN_i) begin
            state_q      <= IDLE;
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            outEn_q      <= 1'b0;
            cacheMiss_q  <= 1'b0;
            bundle_q     <= '0;
            bundleAddr_q <= '0;
            bundleLen_q  <= '0;
            bundlePid_q  <= '0;
            bundleTid_q  <= '0;
            missedAddr_q <= '0;
            missedPid_q  <= '0;
            missedTid_q  <= '0;
        end else begin
            state_q     <= state_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            outEn_q     <= outEn_d;
            cacheMiss_q <= missPulse_d;
            if (outLoad) begin
                bundle_q     <= bundle2;
                bundleAddr_q <= addr_p2_q;
                bundleLen_q  <= len2;
                bundlePid_q  <= pid_p2_q;
                bundleTid_q  <= tid_p2_q;
            end
            if (missLoad) begin
                missedAddr_q <= {addr_p2_q[addrWidth-1:offsetWidth], {offsetWidth{1'b0}}};
                missedPid_q  <= pid_p2_q;
                missedTid_q  <= tid_p2_q;
            end
        end
    end

    // Request payload through the pipeline and the parked missed request.
    always_ff @(posedge clock_i) begin
        if (loadP1) begin
            addr_p1_q <= fetchAddress_i;
            pid_p1_q  <= fetchPid_i;
            tid_p1_q  <= fetchTid_i;
        end
        if (loadP2Fetch) begin
            addr_p2_q <= addr_p1_q;
            pid_p2_q  <= pid_p1_q;
            tid_p2_q  <= tid_p1_q;
        end else if (loadP2Miss) begin
            addr_p2_q <= missAddr_q;
            pid_p2_q  <= missPid_q;
            tid_p2_q  <= missTid_q;
        end
        if (missLoad) begin
            missAddr_q <= addr_p2_q;
            missPid_q  <= pid_p2_q;
            missTid_q  <= tid_p2_q;
        end
    end

    // Valid bits and replacement state; flush clears valids and beats a fill.
    always_ff @(posedge clock_i or negedge cacheResetN_i) begin
        if (!cacheResetN_i) begin
            valid_q <= '0;
            for (int s = 0; s < NumSets; s++) repl_q[s] <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            if (fillWe) begin
                valid_q[fillIdx][fillWay] <= 1'b1;
                repl_q[fillIdx]           <= replFill;
            end
`ifdef L1I_TREE_PLRU_EN
            if (hitUpd) repl_q[idx2] <= replHit;
`endif
        end
    end

    // Tag and line storage written by fills.
    always_ff @(posedge clock_i) begin
        if (fillWe) begin
            tag_q[fillIdx][fillWay]  <= fillTag;
            data_q[fillIdx][fillWay] <= fillLine_i;
        end
    end

    assign outputEnable_o  = outEn_q;
    assign outputBundle_o  = bundle_q;
    assign bundleAddress_o = bundleAddr_q;
    assign bundleLen_o     = bundleLen_q;
    assign bundlePid_o     = bundlePid_q;
    assign bundleTid_o     = bundleTid_q;
    assign cacheMiss_o     = cacheMiss_q;
    assign missedAddress_o = missedAddr_q;
    assign missedPid_o     = missedPid_q;
    assign missedTid_o     = missedTid_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_l1i_set_assoc_cache.sv
// Directed self-checking bench for l1i_set_assoc_cache (default parameters).
module tb_l1i_set_assoc_cache;

    logic         clk = 1'b0;
    logic         rstN;
    logic         fetchEnable, fetchStall, fillValid, flush;
    logic [63:0]  fetchAddress, fillAddress;
    logic [19:0]  fetchPid;
    logic [15:0]  fetchTid;
    logic [511:0] fillLine;

    logic         outEn, cacheMiss, busy;
    logic [127:0] bundle;
    logic [63:0]  bundleAddr, missedAddr;
    logic [2:0]   bundleLen;
    logic [19:0]  bundlePid, missedPid;
    logic [15:0]  bundleTid, missedTid;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    l1i_set_assoc_cache dut (
        .clock_i        (clk),
        .cacheResetN_i  (rstN),
        .fetchEnable_i  (fetchEnable),
        .fetchStall_i   (fetchStall),
        .fetchAddress_i (fetchAddress),
        .fetchPid_i     (fetchPid),
        .fetchTid_i     (fetchTid),
        .fillValid_i    (fillValid),
        .fillAddress_i  (fillAddress),
        .fillLine_i     (fillLine),
        .flush_i        (flush),
        .outputEnable_o (outEn),
        .outputBundle_o (bundle),
        .bundleAddress_o(bundleAddr),
        .bundleLen_o    (bundleLen),
        .bundlePid_o    (bundlePid),
        .bundleTid_o    (bundleTid),
        .cacheMiss_o    (cacheMiss),
        .missedAddress_o(missedAddr),
        .missedPid_o    (missedPid),
        .missedTid_o    (missedTid),
        .busy_o         (busy)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        nChecks++;
        if (got !== want) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word i of the line is seed + i.
    function automatic logic [511:0] mkLine(input logic [31:0] seed);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = seed + 32'(i);
        return l;
    endfunction

    task automatic issue(input logic [63:0] a);
        fetchEnable  = 1'b1;
        fetchAddress = a;
        tick();
        fetchEnable  = 1'b0;
    endtask

    task automatic fill(input logic [63:0] a, input logic [31:0] seed);
        fillValid   = 1'b1;
        fillAddress = a;
        fillLine    = mkLine(seed);
        tick();
        fillValid   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: end of test not reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0; fetchEnable = 1'b0; fetchStall = 1'b0; fillValid = 1'b0; flush = 1'b0;
        fetchAddress = '0; fillAddress = '0; fillLine = '0; fetchPid = '0; fetchTid = '0;

        // Outputs stay zero under reset even with a request pending.
        repeat (2) tick();
        fetchEnable = 1'b1;
        tick();
        chk("rst_outEn", outEn, 0);
        chk("rst_miss", cacheMiss, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len", bundleLen, 0);
        chk("rst_missedAddr", missedAddr, 0);
        fetchEnable = 1'b0;
        rstN = 1'b1;

        // Cold miss on 0x0, then fill and replay.
        fetchPid = 20'h12345; fetchTid = 16'hBEEF;
        issue(64'h0);
        tick();
        chk("miss_not_early", cacheMiss, 0);
        tick();
        chk("miss_pulse", cacheMiss, 1);
        chk("miss_addr", missedAddr, 64'h0);
        chk("miss_pid", missedPid, 20'h12345);
        chk("miss_busy", busy, 1);
        tick();
        chk("miss_once", cacheMiss, 0);
        chk("miss_wait_busy", busy, 1);
        fetchEnable = 1'b1; fetchAddress = 64'h10; fetchPid = '0; fetchTid = '0;
        fill(64'h40, 32'hB0000000);
        fetchEnable = 1'b0;
        chk("fill_nomatch_busy", busy, 1);
        fill(64'h0, 32'hA0000000);
        tick();
        chk("replay_no_out_yet", outEn, 0);
        tick();
        chk("replay_outEn", outEn, 1);
        chk("replay_len", bundleLen, 4);
        chk("replay_bundle", bundle, 128'hA0000003_A0000002_A0000001_A0000000);
        chk("replay_addr", bundleAddr, 64'h0);
        chk("replay_pid", bundlePid, 20'h12345);
        chk("replay_tid", bundleTid, 16'hBEEF);
        chk("replay_idle", busy, 0);
        tick();
        chk("replay_out_once", outEn, 0);

        // Short bundle at the end of the line.
        issue(64'h38);
        tick(); tick();
        chk("tail_outEn", outEn, 1);
        chk("tail_len", bundleLen, 2);
        chk("tail_bundle", bundle, 128'h00000000_00000000_A000000F_A000000E);
        chk("tail_addr", bundleAddr, 64'h38);
        chk("tail_nomiss", cacheMiss, 0);

        // Line installed by the non-matching fill is usable.
        issue(64'h40);
        tick(); tick();
        chk("side_fill_hit", outEn, 1);
        chk("side_fill_bundle", bundle, 128'hB0000003_B0000002_B0000001_B0000000);

        // Back-to-back hits with a two-cycle stall in the middle.
        fetchEnable = 1'b1; fetchAddress = 64'h0;  tick();
        fetchAddress = 64'h10; tick();
        fetchAddress = 64'h20; tick();
        fetchEnable = 1'b0;
        chk("b2b_first_addr", bundleAddr, 64'h0);
        chk("b2b_first_en", outEn, 1);
        fetchStall = 1'b1;
        tick();
        chk("stall1_addr", bundleAddr, 64'h0);
        chk("stall1_en", outEn, 1);
        tick();
        chk("stall2_bundle", bundle, 128'hA0000003_A0000002_A0000001_A0000000);
        fetchStall = 1'b0;
        tick();
        chk("b2b_second_addr", bundleAddr, 64'h10);
        chk("b2b_second_bundle", bundle, 128'hA0000007_A0000006_A0000005_A0000004);
        tick();
        chk("b2b_third_addr", bundleAddr, 64'h20);
        chk("b2b_third_bundle", bundle, 128'hA000000B_A000000A_A0000009_A0000008);
        tick();
        chk("b2b_drained", outEn, 0);

        // Flush invalidates everything.
        flush = 1'b1; tick(); flush = 1'b0;
        issue(64'h0);
        tick(); tick();
        chk("flush_refetch_miss", cacheMiss, 1);
        fill(64'h0, 32'hA0000000);
        tick(); tick();
        chk("flush_refill_hit", outEn, 1);

        // Fill arriving while the lookup is in stage 2 is seen as a hit.
        issue(64'h80);
        tick();
        fill(64'h80, 32'hC0000000);
        chk("fill_bypass_hit", outEn, 1);
        chk("fill_bypass_nomiss", cacheMiss, 0);
        chk("fill_bypass_bundle", bundle, 128'hC0000003_C0000002_C0000001_C0000000);

        // Reset during MISS_WAIT abandons the miss.
        issue(64'hC0);
        tick(); tick();
        chk("pre_reset_busy", busy, 1);
        #2 rstN = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_missedAddr", missedAddr, 0);
        tick(); tick();
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_nomiss", cacheMiss, 0);
        end
        chk("post_rst_idle", busy, 0);
        issue(64'h0);
        tick(); tick();
        chk("post_rst_refetch_miss", cacheMiss, 1);

        // Five tags into set 0 from a clean reset: the first one is evicted.
        rstN = 1'b0; tick(); rstN = 1'b1;
        fill(64'h1000, 32'h11000000);
        fill(64'h2000, 32'h22000000);
        fill(64'h3000, 32'h33000000);
        fill(64'h4000, 32'h44000000);
        fill(64'h5000, 32'h55000000);
        issue(64'h2000);
        tick(); tick();
        chk("evict_keep_b", outEn, 1);
        chk("evict_keep_b_data", bundle, 128'h22000003_22000002_22000001_22000000);
        issue(64'h5000);
        tick(); tick();
        chk("evict_new_e_data", bundle, 128'h55000003_55000002_55000001_55000000);
        issue(64'h1000);
        tick(); tick();
        chk("evict_a_miss", cacheMiss, 1);
        chk("evict_a_noout", outEn, 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/l1i_set_assoc_cache.md
L1I_SET_ASSOC_CACHE -- requirements
Module: l1i_set_assoc_cache

Interface
REQ-001 Parameter addrWidth, 64, fetch/fill address width in bits.
REQ-002 Parameter lineWidth, 512, cache line width in bits (16 x 32-bit instructions).
REQ-003 Parameter offsetWidth, 6, byte offset within a line.
REQ-004 Parameter indexWidth, 6, set index width (2^indexWidth sets).
REQ-005 Parameter numWays, 4, associativity; power of two, 2..8.
REQ-006 Parameter bundleInsts, 4, maximum instructions per output bundle; power of two, 1..8.
REQ-007 Parameters PidSize, 20 and TidSize, 16: process and thread ID widths.
REQ-008 clock_i  in  1  sole clock; all state updates on its rising edge.
REQ-009 cacheResetN_i  in  1  asynchronous, active-low reset.
REQ-010 fetchEnable_i  in  1  fetch request valid.
REQ-011 fetchStall_i  in  1  downstream stall; freezes the pipeline and outputs.
REQ-012 fetchAddress_i  in  addrWidth  byte address of request, 4-byte aligned; fetchPid_i/fetchTid_i  in  PidSize/TidSize.
REQ-013 fillValid_i  in  1  one-cycle fill strobe; fillAddress_i  in  addrWidth; fillLine_i  in  lineWidth.
REQ-014 flush_i  in  1  invalidate all lines.
REQ-015 outputEnable_o  out  1  bundle valid; outputBundle_o  out  bundleInsts*32; bundleAddress_o  out  addrWidth.
REQ-016 bundleLen_o  out  $clog2(bundleInsts)+1  valid instruction count; bundlePid_o/bundleTid_o  out  PidSize/TidSize.
REQ-017 cacheMiss_o  out  1  miss pulse; missedAddress_o  out  addrWidth, line-aligned; missedPid_o/missedTid_o  out.
REQ-018 busy_o  out  1  high while a miss is outstanding.

Function
REQ-019 Address split: tag = upper addrWidth-indexWidth-offsetWidth bits, then index, then offset.
REQ-020 Pipeline: stage 1 registers the request; stage 2 compares all ways' valid+tag; a hit drives outputEnable_o high exactly 2 cycles after the request edge.
REQ-021 Bundle = instructions from offset/4 upward, min(bundleInsts, 16-offset/4) valid, left-justified; unused slots zero; bundleLen_o = valid count.
REQ-022 Requests are accepted every cycle while state is IDLE and fetchStall_i is low.
REQ-023 FSM states IDLE, MISS_WAIT, REPLAY; a stage-2 miss moves IDLE->MISS_WAIT and pulses cacheMiss_o one cycle with line-aligned address and Pid/Tid.
REQ-024 In MISS_WAIT: busy_o=1, new fetchEnable_i ignored, younger stage-1 request discarded, outputEnable_o=0.
REQ-025 fillValid_i writes the line into the set's victim way, sets valid, updates replacement state; MISS_WAIT->REPLAY only if fill line matches the missed line, else fill is installed and state is unchanged.
REQ-026 REPLAY re-presents the missed request to stage 2; the hit bundle appears the next cycle; state returns to IDLE.
REQ-027 Victim = first invalid way (lowest index); if all valid, replacement policy per REQ-034/035.
REQ-028 fetchStall_i high: all registers and outputs hold, cacheMiss_o pulse not repeated; fills are still written.
REQ-029 Fill and lookup to the same set in one cycle: fill writes first; lookup observes the filled line (hit).
REQ-030 flush_i clears all valid bits next edge, drops in-flight requests, returns FSM to IDLE; flush_i has priority over a coincident fill.
REQ-031 A hit updates replacement state for that set; a miss does not.

Reset
REQ-032 cacheResetN_i low asynchronously clears all valid bits, replacement state, pipeline valids; FSM to IDLE.
REQ-033 During reset all outputs are 0; reset mid-miss abandons the miss with no further cacheMiss_o.

Configuration
REQ-034 With L1I_TREE_PLRU_EN defined, each set keeps numWays-1 tree-PLRU bits; victim follows the tree.
REQ-035 Without L1I_TREE_PLRU_EN, each set keeps a $clog2(numWays)-bit round-robin counter, incremented on every fill to that set.

Verification
REQ-036 Reset, fetch 0x0 -> cacheMiss_o=1 one cycle, missedAddress_o=0x0, busy_o=1; fill 0x0 -> bundle 2 cycles later, bundleLen_o=4.
REQ-037 Fetch 0x38 after line 0x0 filled -> bundleLen_o=2, slots 2..3 zero, bundleAddress_o=0x38.
REQ-038 Fill 5 distinct tags to set 0 (numWays=4), no hits -> first-filled line evicted; refetch it misses.
REQ-039 Back-to-back hits 0x0,0x10,0x20 with fetchStall_i high for 2 middle cycles -> three bundles in order, outputs frozen during stall.
REQ-040 Reset asserted during MISS_WAIT, then released -> busy_o=0, no cacheMiss_o, fetch 0x0 misses again.
